// File: rtl/aes_key_expander.sv
// AES-128 key schedule: accepts one cipher key and streams round keys 0..10
// over a valid/ready handshake, then pulses done for one cycle.
module aes_key_expander (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_key_idx,
  output logic         round_key_valid,
  input  logic         round_key_ready,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = 11'd2047 - {x, 3'b000};
    return SBOX[pos -: 8];
  endfunction

  state_t       r_state, w_next;
  logic [127:0] r_key, w_next_key;
  logic [3:0]   r_idx;
  logic [7:0]   r_rcon, w_rcon_x2;
  logic [31:0]  w_rot, w_t, w_n0, w_n1, w_n2, w_n3;
  logic         w_hs, w_last;

  assign w_hs      = (r_state == EMIT) && round_key_ready;
  assign w_last    = (r_idx == 4'd10);
  assign w_rcon_x2 = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  assign w_rot = {r_key[23:0], r_key[31:24]};
  assign w_t   = {sbox(w_rot[31:24]) ^ r_rcon, sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_n0  = r_key[127:96] ^ w_t;
  assign w_n1  = r_key[95:64]  ^ w_n0;
  assign w_n2  = r_key[63:32]  ^ w_n1;
  assign w_n3  = r_key[31:0]   ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (key_valid) w_next = EMIT;
      EMIT:    if (w_hs && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_idx  <= '0;
      r_rcon <= 8'h01;
    end else if (r_state == IDLE && key_valid) begin
      r_key  <= key_in;
      r_idx  <= '0;
      r_rcon <= 8'h01;
    end else if (w_hs && !w_last) begin
      r_key  <= w_next_key;
      r_idx  <= r_idx + 4'd1;
      r_rcon <= w_rcon_x2;
    end
  end

  assign key_ready       = (r_state == IDLE);
  assign round_key_valid = (r_state == EMIT);
  assign done            = (r_state == DONE);
  assign round_key       = r_key;
  assign round_key_idx   = r_idx;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: stimulus queues expected round keys,
// a negedge monitor pops and compares on every handshake.
module tb_aes_key_expander;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_key_idx;
  logic         round_key_valid;
  logic         round_key_ready;
  logic         done;

  aes_key_expander dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .round_key(round_key), .round_key_idx(round_key_idx),
    .round_key_valid(round_key_valid), .round_key_ready(round_key_ready), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t sb[$];
  int nvec = 0, nfail = 0, hs_cnt = 0, done_cnt = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [127:0] fips_rk(input int i);
    case (i)
      0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
      1:  return 128'ha0fafe1788542cb123a339392a6c7605;
      2:  return 128'hf2c295f27a96b9435935807a7359f67f;
      3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
      4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
      5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
      7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      8:  return 128'head27321b58dbad2312bf5607f8d292f;
      9:  return 128'hac7766f319fadc2128d12941575c006e;
      default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    endcase
  endfunction

  function automatic logic [127:0] zero_rk(input int i);
    case (i)
      0:  return 128'h0;
      1:  return 128'h62636363626363636263636362636363;
      default: return 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: handshakes, stall stability, done timing, key_ready exclusivity.
  bit           prev_stall = 0, exp_done = 0;
  logic [127:0] saved_key;
  logic [3:0]   saved_idx;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      exp_done   = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_key", round_key, saved_key);
        chk("stall_idx", {124'h0, round_key_idx}, {124'h0, saved_idx});
      end
      if (exp_done || done) chk("done_pulse", {127'h0, done}, {127'h0, exp_done});
      exp_done = 0;
      if (done) done_cnt++;
      if (round_key_valid) chk("key_ready_in_emit", {127'h0, key_ready}, 128'h0);
      if (round_key_valid && round_key_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_handshake", {124'h0, round_key_idx}, 128'hf);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("round_key_idx", {124'h0, round_key_idx}, {124'h0, e.idx});
          if (e.chk) chk($sformatf("round_key[%0d]", e.idx), round_key, e.key);
        end
        if (round_key_idx == 4'd10) exp_done = 1;
      end
      prev_stall = round_key_valid && !round_key_ready;
      saved_key  = round_key;
      saved_idx  = round_key_idx;
    end
  end

  task automatic push_expected(input logic [127:0] k);
    for (int i = 0; i <= 10; i++) begin
      exp_t e;
      e.idx = 4'(i);
      if (k == FIPS_KEY) begin
        e.key = fips_rk(i); e.chk = 1;
      end else begin
        e.key = zero_rk(i); e.chk = (k == 128'h0) && (i <= 2);
      end
      sb.push_back(e);
    end
  endtask

  // mode 0: ready held 1; mode 1: random stalls; mode 2: key_valid held with other key
  task automatic run(input logic [127:0] k, input int mode, input string tag);
    int hs0, d0, cyc;
    bit seen;
    hs0 = hs_cnt; d0 = done_cnt; seen = 0;
    push_expected(k);
    @(posedge clk); #1;
    chk({tag, "_key_ready_idle"}, {127'h0, key_ready}, 128'h1);
    key_in = k; key_valid = 1'b1;
    round_key_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    chk({tag, "_latency1_valid"}, {127'h0, round_key_valid}, 128'h1);
    if (mode == 2) key_in = ~k;
    else           key_valid = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (done) begin seen = 1; break; end
      if (mode == 1) round_key_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    round_key_ready = 1'b1;
    chk({tag, "_done_seen"}, {127'h0, seen}, 128'h1);
    @(negedge clk); #1;
    chk({tag, "_handshakes"}, 128'(hs_cnt - hs0), 128'd11);
    chk({tag, "_done_count"}, 128'(done_cnt - d0), 128'd1);
    chk({tag, "_queue_empty"}, 128'(sb.size()), 128'd0);
    @(posedge clk); #1;
    chk({tag, "_back_idle"}, {127'h0, key_ready}, 128'h1);
  endtask

  initial begin
    int d0, cyc;
    rst_n = 1'b0; key_in = '0; key_valid = 1'b0; round_key_ready = 1'b0;
    #2;
    chk("rst_round_key", round_key, 128'h0);
    chk("rst_idx", {124'h0, round_key_idx}, 128'h0);
    chk("rst_valid", {127'h0, round_key_valid}, 128'h0);
    chk("rst_done", {127'h0, done}, 128'h0);
    chk("rst_key_ready", {127'h0, key_ready}, 128'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ready asserted while nothing valid must do nothing.
    round_key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_ready_noeffect", {127'h0, round_key_valid}, 128'h0);

    run(FIPS_KEY, 0, "fips");
    run(128'h0, 0, "zero");
    run(FIPS_KEY, 1, "stall");
    run(FIPS_KEY, 2, "kv_hold");

    // Reset in the middle of an expansion.
    push_expected(FIPS_KEY);
    @(posedge clk); #1;
    key_in = FIPS_KEY; key_valid = 1'b1; round_key_ready = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    for (cyc = 0; cyc < 50 && round_key_idx != 4'd5; cyc++) begin
      @(posedge clk); #1;
    end
    chk("mid_reach_idx5", {124'h0, round_key_idx}, 128'h5);
    @(negedge clk); #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_round_key", round_key, 128'h0);
    chk("midrst_idx", {124'h0, round_key_idx}, 128'h0);
    chk("midrst_valid", {127'h0, round_key_valid}, 128'h0);
    chk("midrst_key_ready", {127'h0, key_ready}, 128'h1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("midrst_no_done", 128'(done_cnt - d0), 128'd0);

    run(FIPS_KEY, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
